// File: rtl/riscv_pipelined_fetch_pkg.sv
// Shared definitions for the pipelined IF stage: reset PC, FSM states, NOP encoding
// and the {pc, instr} entry held by the instruction buffer.
package riscv_pipelined_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

    typedef enum logic {
        FETCH_STATE_IDLE = 1'b0,
        FETCH_STATE_RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_pipelined_fetch_buf.sv
// Synchronous FIFO with push, pop, clear and occupancy count; DEPTH must be a power of two.
// Clear wins over push/pop; push into a full FIFO is accepted only alongside a pop.
module riscv_pipelined_fetch_buf #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL) || do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/riscv_pipelined_fetch.sv
// IF stage: PC, imem req/gnt/rvalid handshake, instruction buffer and IF/ID register.
// Optional macro FETCH_MISALIGN_CHK_EN adds o_fetch_misalign and halts fetch on misaligned redirects.
module riscv_pipelined_fetch
    import riscv_pipelined_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    output logic        o_fetch_imem_req,
    output logic [31:0] o_fetch_imem_addr,
    input  logic        i_fetch_imem_gnt,
    input  logic        i_fetch_imem_rvalid,
    input  logic [31:0] i_fetch_imem_rdata,
    input  logic        i_fetch_stall,
    input  logic        i_fetch_redirect,
    input  logic [31:0] i_fetch_redirect_pc,
    output logic        o_fetch_valid,
    output logic [31:0] o_fetch_instr,
    output logic [31:0] o_fetch_pc,
    output logic [31:0] o_fetch_pc4
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        o_fetch_misalign
`endif
);

    localparam int unsigned CW = $clog2(BUF_DEPTH+1);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d;
    logic          valid_q, valid_d, misalign_q, misalign_d;
    logic [31:0]   instr_q, instr_d, ifid_pc_q, ifid_pc_d;
    logic [31:0]   redir_pc;
    logic          req, fire, rsp_live, bypass, ifid_open;
    fetch_entry_t  buf_wdata, buf_rdata;
    logic          buf_push, buf_pop;
    logic [CW-1:0] buf_count, tag_count_unused;
    logic [31:0]   tag_head;

`ifdef FETCH_MISALIGN_CHK_EN
    assign redir_pc         = i_fetch_redirect_pc;
    assign o_fetch_misalign = misalign_q;
`else
    logic unused_redir_lsb;
    assign redir_pc         = {i_fetch_redirect_pc[31:2], 2'b00};
    assign unused_redir_lsb = ^i_fetch_redirect_pc[1:0];
`endif

    assign req       = (state_q == FETCH_STATE_RUN) && !i_fetch_redirect && !misalign_q
                     && (({1'b0, inflight_q} + {1'b0, buf_count}) < DEPTH_W);
    assign fire      = req && i_fetch_imem_gnt;
    assign rsp_live  = i_fetch_imem_rvalid && (drop_q == '0) && !i_fetch_redirect;
    assign ifid_open = !i_fetch_redirect && !misalign_q && (!i_fetch_stall || !valid_q);
    assign bypass    = ifid_open && (buf_count == '0) && rsp_live;
    assign buf_pop   = ifid_open && (buf_count != '0);
    assign buf_push  = rsp_live && !bypass;
    assign buf_wdata = '{pc: tag_head, instr: i_fetch_imem_rdata};

    // inflight counts every outstanding beat, stale or not, so the tag queue
    // can never hold more than BUF_DEPTH entries; drop marks the stale subset.
    always_comb begin
        state_d    = FETCH_STATE_RUN;
        pc_d       = pc_q;
        inflight_d = inflight_q + CW'(fire) - CW'(i_fetch_imem_rvalid);
        drop_d     = drop_q;
        misalign_d = misalign_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        ifid_pc_d  = ifid_pc_q;

        if (i_fetch_redirect) begin
            pc_d       = redir_pc;
            drop_d     = inflight_q - CW'(i_fetch_imem_rvalid);
            misalign_d = |redir_pc[1:0];
        end else begin
            if (fire) pc_d = pc_q + 32'd4;
            if (i_fetch_imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
        end

        if (i_fetch_redirect || misalign_q) begin
            valid_d = 1'b0;
        end else if (ifid_open) begin
            if (buf_count != '0) begin
                valid_d   = 1'b1;
                instr_d   = buf_rdata.instr;
                ifid_pc_d = buf_rdata.pc;
            end else if (rsp_live) begin
                valid_d   = 1'b1;
                instr_d   = i_fetch_imem_rdata;
                ifid_pc_d = tag_head;
            end else begin
                valid_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q    <= FETCH_STATE_IDLE;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            misalign_q <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= INSTR_NOP;
            ifid_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            misalign_q <= misalign_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            ifid_pc_q  <= ifid_pc_d;
        end
    end

    riscv_pipelined_fetch_buf #(.WIDTH(64), .DEPTH(BUF_DEPTH)) u_ibuf (
        .clk_i   (i_clk),
        .rst_ni  (i_rstn),
        .push_i  (buf_push),
        .wdata_i (buf_wdata),
        .pop_i   (buf_pop),
        .clear_i (i_fetch_redirect),
        .rdata_o (buf_rdata),
        .count_o (buf_count)
    );

    riscv_pipelined_fetch_buf #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_tagq (
        .clk_i   (i_clk),
        .rst_ni  (i_rstn),
        .push_i  (fire),
        .wdata_i (pc_q),
        .pop_i   (i_fetch_imem_rvalid),
        .clear_i (1'b0),
        .rdata_o (tag_head),
        .count_o (tag_count_unused)
    );

    assign o_fetch_imem_req  = req;
    assign o_fetch_imem_addr = pc_q;
    assign o_fetch_valid     = valid_q;
    assign o_fetch_instr     = instr_q;
    assign o_fetch_pc        = ifid_pc_q;
    assign o_fetch_pc4       = ifid_pc_q + 32'd4;

endmodule
